// File: rtl/q_8_29_rtl_pkg.sv
// Shared types for the q_8_29_rtl state machine: the 3-bit state enum
// whose encoding is also the externally visible state code.
package q_8_29_rtl_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_e;

endpackage

// File: rtl/q_8_29_rtl_decoder.sv
// 3-to-8 one-hot decoder: bit n of dec_out is set iff sel == n.
module decoder_3to8 (
  input  logic [2:0] sel,
  output logic [7:0] dec_out
);

  always_comb begin
    dec_out = 8'h00;
    dec_out[sel] = 1'b1;
  end

endmodule

// File: rtl/q_8_29_rtl.sv
// Eight-state Moore FSM with two start paths (x via S1, y direct to S2),
// F/E branch selects, and a one-hot decode of the current state.
module q_8_29_rtl
  import q_8_29_rtl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       x,
  input  logic       y,
  input  logic       F,
  input  logic       E,
  output logic [2:0] state,
  output logic [7:0] dec_out
);

  state_e state_q;
  state_e state_d;

  // Each input is looked at only in the one state that consumes it.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: begin
        if (x)      state_d = S1;
        else if (y) state_d = S2;
        else        state_d = S0;
      end
      S1:      state_d = S2;
      S2:      state_d = F ? S3 : S4;
      S3:      state_d = S0;
      S4:      state_d = E ? S5 : S6;
      S5:      state_d = S0;
      S6:      state_d = S7;
      S7:      state_d = S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S0;
    else        state_q <= state_d;
  end

  assign state = state_q;

  decoder_3to8 u_decoder (
    .sel     (state_q),
    .dec_out (dec_out)
  );

endmodule

// File: tb/tb_q_8_29_rtl.sv
// Directed bench for q_8_29_rtl: walks every path of the state graph and
// checks state and dec_out one cycle at a time against hand-built tables.
module tb_q_8_29_rtl;

  logic       clk;
  logic       rst_b;
  logic       x;
  logic       y;
  logic       F;
  logic       E;
  logic [2:0] state;
  logic [7:0] dec_out;

  int n_checks;
  int n_fail;

  q_8_29_rtl dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .x       (x),
    .y       (y),
    .F       (F),
    .E       (E),
    .state   (state),
    .dec_out (dec_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_b = 1'b0; x = 1'b0; y = 1'b0; F = 1'b0; E = 1'b0;
    #3;
    n_checks++;
    if (state !== 3'd0 || dec_out !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_async: state=%0d dec_out=%h, expected state=0 dec_out=01", state, dec_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0 || dec_out !== 8'h01) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: state=%0d dec_out=%h, expected state=0 dec_out=01", i, state, dec_out);
      end
    end
  endtask

  task automatic test_x_path();
    logic [2:0] es [6];
    logic [7:0] ed [6];
    es = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7, 3'd0};
    ed = '{8'h02, 8'h04, 8'h10, 8'h40, 8'h80, 8'h01};
    x = 1'b1; y = 1'b0; F = 1'b0; E = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) x = 1'b0;
      n_checks++;
      if (state !== es[i] || dec_out !== ed[i]) begin
        n_fail++;
        $display("FAIL x_path step %0d: state=%0d dec_out=%h, expected state=%0d dec_out=%h", i, state, dec_out, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_y_path();
    logic [2:0] es [10];
    logic [7:0] ed [10];
    es = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6, 3'd7, 3'd0};
    ed = '{8'h04, 8'h10, 8'h40, 8'h80, 8'h01, 8'h04, 8'h10, 8'h40, 8'h80, 8'h01};
    x = 1'b0; y = 1'b1; F = 1'b0; E = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 8) y = 1'b0;
      n_checks++;
      if (state !== es[i] || dec_out !== ed[i]) begin
        n_fail++;
        $display("FAIL y_path step %0d: state=%0d dec_out=%h, expected state=%0d dec_out=%h", i, state, dec_out, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_f_branch();
    logic [2:0] es [6];
    logic [7:0] ed [6];
    es = '{3'd2, 3'd3, 3'd0, 3'd2, 3'd3, 3'd0};
    ed = '{8'h04, 8'h08, 8'h01, 8'h04, 8'h08, 8'h01};
    x = 1'b0; y = 1'b1; F = 1'b1; E = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) begin y = 1'b0; F = 1'b0; end
      n_checks++;
      if (state !== es[i] || dec_out !== ed[i]) begin
        n_fail++;
        $display("FAIL f_branch step %0d: state=%0d dec_out=%h, expected state=%0d dec_out=%h", i, state, dec_out, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_e_branch();
    logic [2:0] es [4];
    logic [7:0] ed [4];
    es = '{3'd2, 3'd4, 3'd5, 3'd0};
    ed = '{8'h04, 8'h10, 8'h20, 8'h01};
    x = 1'b0; y = 1'b1; F = 1'b0; E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) begin y = 1'b0; E = 1'b0; end
      n_checks++;
      if (state !== es[i] || dec_out !== ed[i]) begin
        n_fail++;
        $display("FAIL e_branch step %0d: state=%0d dec_out=%h, expected state=%0d dec_out=%h", i, state, dec_out, es[i], ed[i]);
      end
    end
  endtask

  // x and y together must take the S1 path.
  task automatic test_priority();
    logic [2:0] es [6];
    logic [7:0] ed [6];
    es = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7, 3'd0};
    ed = '{8'h02, 8'h04, 8'h10, 8'h40, 8'h80, 8'h01};
    x = 1'b1; y = 1'b1; F = 1'b0; E = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin x = 1'b0; y = 1'b0; end
      n_checks++;
      if (state !== es[i] || dec_out !== ed[i]) begin
        n_fail++;
        $display("FAIL priority step %0d: state=%0d dec_out=%h, expected state=%0d dec_out=%h", i, state, dec_out, es[i], ed[i]);
      end
    end
  endtask

  // Inputs raised in states that do not consume them must have no effect.
  task automatic test_ignore();
    logic [2:0] es [11];
    es = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7, 3'd0};
    x = 1'b0; y = 1'b1; F = 1'b0; E = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 2) begin x = 1'b1; F = 1'b1; E = 1'b1; end
      if (i == 5) begin x = 1'b0; y = 1'b0; F = 1'b0; E = 1'b0; end
      n_checks++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL ignore step %0d: state=%0d, expected state=%0d", i, state, es[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    x = 1'b0; y = 1'b1; F = 1'b0; E = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_reset_pre: state=%0d, expected state=4", state);
    end
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || dec_out !== 8'h01) begin
      n_fail++;
      $display("FAIL mid_reset_async: state=%0d dec_out=%h, expected state=0 dec_out=01", state, dec_out);
    end
    @(negedge clk);
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset_held: state=%0d, expected state=0", state);
    end
    #2 rst_b = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state !== 3'd2 || dec_out !== 8'h04) begin
      n_fail++;
      $display("FAIL mid_reset_resume: state=%0d dec_out=%h, expected state=2 dec_out=04", state, dec_out);
    end
    y = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_reset_resume2: state=%0d, expected state=4", state);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset_return: state=%0d, expected state=0", state);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_x_path();
    test_y_path();
    test_f_branch();
    test_e_branch();
    test_priority();
    test_ignore();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
